// File: rtl/counter_run_ctrl_pkg.sv
// Shared types for the up-counter run-control sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_run_ctrl_pkg;

  // Run-control state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Terminal-count behaviour, latched at an accepted start
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_core_up.sv
// Plain DATA_SIZE-bit up-counter with synchronous clear and enable.
// Latency: count updates one cycle after clr/en.
// Backpressure: none; clr takes priority over en.
module counter_core_up #(
  parameter int DATA_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [DATA_SIZE-1:0] q
);

  // Clear wins over enable so a reload at terminal count lands on zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run-control sequencer: start/pause/terminal-count/stop-or-wrap for an up-counter.
// Latency: commands take effect at the next rising edge; status is decoded from state.
// Backpressure: none; start is ignored while busy, abort always wins.
module counter_run_ctrl
  import counter_run_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = 4,
  parameter int PRE_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 hold,
  input  logic                 auto_reload,
  input  logic [DATA_SIZE-1:0] limit_in,
  input  logic [PRE_SIZE-1:0]  prescale_in,
  output logic [DATA_SIZE-1:0] q_out,
  output logic                 tc_pulse,
  output logic                 busy,
  output logic                 done
);

  state_e               state, state_nxt;
  logic [DATA_SIZE-1:0] limit_lat;
  logic [PRE_SIZE-1:0]  prescale_lat;
  logic                 mode_lat;
  logic [PRE_SIZE-1:0]  presc, presc_nxt;
  logic                 tc_nxt;
  logic                 cfg_latch;
  logic                 core_clr;
  logic                 core_en;
  logic                 at_limit;
  logic                 presc_wrap;

  assign at_limit   = (q_out == limit_lat);
  assign presc_wrap = (presc == prescale_lat);

  // Next-state and datapath control, priority abort > start > hold > tick
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    tc_nxt    = 1'b0;
    cfg_latch = 1'b0;
    core_clr  = 1'b0;
    core_en   = 1'b0;
    case (state)
      IDLE: begin
        if (!abort && start) begin
          cfg_latch = 1'b1;
          core_clr  = 1'b1;
          presc_nxt = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          core_clr  = 1'b1;
          presc_nxt = '0;
          state_nxt = IDLE;
        end else if (hold) begin
          state_nxt = PAUSE;
        end else if (presc_wrap) begin
          presc_nxt = '0;
          if (at_limit) begin
            tc_nxt = 1'b1;
            if (mode_lat == MODE_RELOAD) begin
              core_clr = 1'b1;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            core_en = 1'b1;
          end
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      PAUSE: begin
        if (abort) begin
          core_clr  = 1'b1;
          presc_nxt = '0;
          state_nxt = IDLE;
        end else if (!hold) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (abort) begin
          core_clr  = 1'b1;
          presc_nxt = '0;
          state_nxt = IDLE;
        end else if (start) begin
          cfg_latch = 1'b1;
          core_clr  = 1'b1;
          presc_nxt = '0;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, prescaler and terminal-count pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      presc    <= '0;
      tc_pulse <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      tc_pulse <= tc_nxt;
    end
  end

  // Run configuration is captured only on an accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit_lat    <= '0;
      prescale_lat <= '0;
      mode_lat     <= MODE_ONESHOT;
    end else if (cfg_latch) begin
      limit_lat    <= limit_in;
      prescale_lat <= prescale_in;
      mode_lat     <= auto_reload;
    end
  end

  counter_core_up #(
    .DATA_SIZE (DATA_SIZE)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (core_clr),
    .en      (core_en),
    .q       (q_out)
  );

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_counter_run_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       hold = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] limit_in = '0;
  logic [7:0] prescale_in = '0;
  logic [3:0] q_out;
  logic       tc_pulse;
  logic       busy;
  logic       done;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  counter_run_ctrl #(
    .DATA_SIZE (4),
    .PRE_SIZE  (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .hold        (hold),
    .auto_reload (auto_reload),
    .limit_in    (limit_in),
    .prescale_in (prescale_in),
    .q_out       (q_out),
    .tc_pulse    (tc_pulse),
    .busy        (busy),
    .done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] lim, input logic [7:0] pre, input logic ar);
    limit_in    = lim;
    prescale_in = pre;
    auto_reload = ar;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (q_out !== 4'd0) $display("FAIL reset_q got %0d want 0", q_out); else passed++;
    checks++; if (tc_pulse !== 1'b0) $display("FAIL reset_tc got %b want 0", tc_pulse); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_oneshot();
    do_start(4'd3, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (q_out !== 4'(i)) $display("FAIL oneshot_q[%0d] got %0d want %0d", i, q_out, i); else passed++;
      checks++; if (tc_pulse !== 1'b0 || busy !== 1'b1) $display("FAIL oneshot_run[%0d] got tc=%b busy=%b want tc=0 busy=1", i, tc_pulse, busy); else passed++;
      tick();
    end
    checks++; if (tc_pulse !== 1'b1) $display("FAIL oneshot_tc got %b want 1", tc_pulse); else passed++;
    checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL oneshot_done got done=%b busy=%b want done=1 busy=0", done, busy); else passed++;
    checks++; if (q_out !== 4'd3) $display("FAIL oneshot_hold_q got %0d want 3", q_out); else passed++;
    tick();
    checks++; if (tc_pulse !== 1'b0 || q_out !== 4'd3 || done !== 1'b1) $display("FAIL oneshot_after got tc=%b q=%0d done=%b want tc=0 q=3 done=1", tc_pulse, q_out, done); else passed++;
  endtask

  task automatic test_reload();
    logic [3:0] exp_q;
    logic       exp_tc;
    do_start(4'd2, 8'd1, 1'b1);
    for (int i = 0; i < 14; i++) begin
      exp_q  = 4'((i / 2) % 3);
      exp_tc = (i > 0) && (i % 6 == 0);
      checks++; if (q_out !== exp_q) $display("FAIL reload_q[%0d] got %0d want %0d", i, q_out, exp_q); else passed++;
      checks++; if (tc_pulse !== exp_tc) $display("FAIL reload_tc[%0d] got %b want %b", i, tc_pulse, exp_tc); else passed++;
      checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL reload_status[%0d] got busy=%b done=%b want 1/0", i, busy, done); else passed++;
      tick();
    end
    do_abort();
    checks++; if (q_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL reload_abort got q=%0d busy=%b done=%b want 0/0/0", q_out, busy, done); else passed++;
  endtask

  task automatic test_hold();
    do_start(4'd7, 8'd0, 1'b0);
    repeat (4) tick();
    checks++; if (q_out !== 4'd4) $display("FAIL hold_pre_q got %0d want 4", q_out); else passed++;
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (q_out !== 4'd4 || busy !== 1'b1 || tc_pulse !== 1'b0) $display("FAIL hold_frozen[%0d] got q=%0d busy=%b tc=%b want 4/1/0", i, q_out, busy, tc_pulse); else passed++;
    end
    hold = 1'b0;
    tick();
    checks++; if (q_out !== 4'd4) $display("FAIL hold_resume_edge got %0d want 4", q_out); else passed++;
    for (int v = 5; v <= 7; v++) begin
      tick();
      checks++; if (q_out !== 4'(v)) $display("FAIL hold_resume_q got %0d want %0d", q_out, v); else passed++;
    end
    tick();
    checks++; if (tc_pulse !== 1'b1 || done !== 1'b1 || q_out !== 4'd7) $display("FAIL hold_tc got tc=%b done=%b q=%0d want 1/1/7", tc_pulse, done, q_out); else passed++;
  endtask

  task automatic test_abort_pause();
    do_start(4'd7, 8'd0, 1'b0);
    repeat (5) tick();
    hold = 1'b1;
    tick();
    checks++; if (q_out !== 4'd5 || busy !== 1'b1) $display("FAIL abortp_paused got q=%0d busy=%b want 5/1", q_out, busy); else passed++;
    do_abort();
    hold = 1'b0;
    checks++; if (q_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || tc_pulse !== 1'b0) $display("FAIL abortp_idle got q=%0d busy=%b done=%b tc=%b want 0/0/0/0", q_out, busy, done, tc_pulse); else passed++;
    tick();
    checks++; if (q_out !== 4'd0 || tc_pulse !== 1'b0 || busy !== 1'b0) $display("FAIL abortp_stay got q=%0d tc=%b busy=%b want 0/0/0", q_out, tc_pulse, busy); else passed++;
  endtask

  task automatic test_start_abort_done();
    do_start(4'd2, 8'd0, 1'b0);
    repeat (3) tick();
    checks++; if (done !== 1'b1 || q_out !== 4'd2) $display("FAIL sad_reach_done got done=%b q=%0d want 1/2", done, q_out); else passed++;
    limit_in = 4'd9;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (q_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL sad_abort_wins got q=%0d busy=%b done=%b want 0/0/0", q_out, busy, done); else passed++;
    do_start(4'd1, 8'd0, 1'b0);
    checks++; if (q_out !== 4'd0 || busy !== 1'b1) $display("FAIL sad_restart got q=%0d busy=%b want 0/1", q_out, busy); else passed++;
    tick();
    checks++; if (q_out !== 4'd1 || tc_pulse !== 1'b0) $display("FAIL sad_q1 got q=%0d tc=%b want 1/0", q_out, tc_pulse); else passed++;
    tick();
    checks++; if (tc_pulse !== 1'b1 || done !== 1'b1 || q_out !== 4'd1) $display("FAIL sad_tc got tc=%b done=%b q=%0d want 1/1/1", tc_pulse, done, q_out); else passed++;
  endtask

  task automatic test_start_ignored();
    do_start(4'd5, 8'd2, 1'b0);
    repeat (2) tick();
    limit_in    = 4'd1;
    prescale_in = 8'd0;
    auto_reload = 1'b1;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    checks++; if (q_out !== 4'd1) $display("FAIL ign_q_e3 got %0d want 1", q_out); else passed++;
    repeat (3) tick();
    checks++; if (q_out !== 4'd2 || busy !== 1'b1) $display("FAIL ign_q_e6 got q=%0d busy=%b want 2/1", q_out, busy); else passed++;
    repeat (12) tick();
    checks++; if (tc_pulse !== 1'b1 || done !== 1'b1 || q_out !== 4'd5) $display("FAIL ign_tc got tc=%b done=%b q=%0d want 1/1/5", tc_pulse, done, q_out); else passed++;
  endtask

  task automatic test_limit_zero();
    do_start(4'd0, 8'd0, 1'b1);
    checks++; if (q_out !== 4'd0 || tc_pulse !== 1'b0) $display("FAIL lim0_start got q=%0d tc=%b want 0/0", q_out, tc_pulse); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (tc_pulse !== 1'b1 || q_out !== 4'd0 || busy !== 1'b1) $display("FAIL lim0_tick[%0d] got tc=%b q=%0d busy=%b want 1/0/1", i, tc_pulse, q_out, busy); else passed++;
    end
    do_abort();
  endtask

  task automatic test_full_range();
    do_start(4'd15, 8'd0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++; if (q_out !== 4'(i) || tc_pulse !== 1'b0) $display("FAIL full_q got q=%0d tc=%b want %0d/0", q_out, tc_pulse, i); else passed++;
    end
    tick();
    checks++; if (q_out !== 4'd0 || tc_pulse !== 1'b1 || busy !== 1'b1) $display("FAIL full_wrap got q=%0d tc=%b busy=%b want 0/1/1", q_out, tc_pulse, busy); else passed++;
    tick();
    checks++; if (q_out !== 4'd1 || tc_pulse !== 1'b0) $display("FAIL full_after got q=%0d tc=%b want 1/0", q_out, tc_pulse); else passed++;
    do_abort();
  endtask

  task automatic test_reset_mid();
    do_start(4'd10, 8'd0, 1'b0);
    repeat (6) tick();
    checks++; if (q_out !== 4'd6) $display("FAIL rstmid_pre got %0d want 6", q_out); else passed++;
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (q_out !== 4'd0 || busy !== 1'b0 || tc_pulse !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_async got q=%0d busy=%b tc=%b done=%b want 0/0/0/0", q_out, busy, tc_pulse, done); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    do_start(4'd3, 8'd0, 1'b0);
    checks++; if (q_out !== 4'd0 || busy !== 1'b1) $display("FAIL rstmid_restart got q=%0d busy=%b want 0/1", q_out, busy); else passed++;
    tick();
    checks++; if (q_out !== 4'd1) $display("FAIL rstmid_q1 got %0d want 1", q_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_hold();
    test_abort_pause();
    test_start_abort_done();
    test_start_ignored();
    test_limit_zero();
    test_full_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
